// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   Transmit-side scheduler for the UART. Two byte requesters (APB write path
//   and RX echo path) are round-robin arbitrated into a small TX FIFO. A
//   sequencer then drives the UART_TX engine one frame at a time: it pops a
//   byte, issues a one-cycle start pulse, waits for done (or a timeout), and
//   then holds off for an inter-frame gap before the next start.
//
// Ports
//   pClk, pReset        : clock, synchronous active-high reset
//   i_enable            : allows new frames to start (FIFO always accepts)
//   i_req0_valid/data   : requester 0 (APB write path) byte offer
//   o_req0_ready        : requester 0 grant (combinational)
//   i_req1_valid/data   : requester 1 (RX echo path) byte offer
//   o_req1_ready        : requester 1 grant (combinational)
//   o_tx_start          : one-cycle start pulse to UART_TX
//   o_tx_data           : byte for UART_TX, stable for the whole frame
//   i_tx_done           : end-of-frame pulse from UART_TX
//   i_clr_timeout       : clears the sticky timeout flag
//   o_level             : FIFO occupancy, 0..DEPTH
//   o_busy              : sequencer not idle or FIFO not empty
//   o_timeout           : sticky flag, a frame was aborted for lack of done
//
// TIMEOUT_CYCLES is expected to be at least 2.
// ---------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int DEPTH          = 8,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                   pClk,
   input  logic                   pReset,
   input  logic                   i_enable,
   input  logic                   i_req0_valid,
   input  logic [7:0]             i_req0_data,
   output logic                   o_req0_ready,
   input  logic                   i_req1_valid,
   input  logic [7:0]             i_req1_data,
   output logic                   o_req1_ready,
   output logic                   o_tx_start,
   output logic [7:0]             o_tx_data,
   input  logic                   i_tx_done,
   input  logic                   i_clr_timeout,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;

   logic [7:0]      fifo_mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [LW-1:0]   level_s;
   logic            prefer1_r;

   logic [7:0]      tx_data_r;
   logic            tx_start_r;
   logic            timeout_r;
   logic            busy_r;
   logic [TW-1:0]   tout_cnt_r;
   logic [TW-1:0]   tout_cnt_s;
   logic [GW-1:0]   gap_cnt_r;
   logic [GW-1:0]   gap_cnt_s;

   logic            full_s;
   logic            empty_s;
   logic            ready0_s;
   logic            ready1_s;
   logic            push0_s;
   logic            push1_s;
   logic            push_s;
   logic [7:0]      push_data_s;
   logic            pop_s;
   logic            timeout_set_s;

   // Arbitration: each ready looks only at the other requester's valid, so a
   // requester's own valid never loops back into its ready.
   always_comb begin
      full_s      = (level_r == LW'(DEPTH));
      empty_s     = (level_r == LW'(0));
      ready0_s    = !full_s && (!i_req1_valid || !prefer1_r);
      ready1_s    = !full_s && (!i_req0_valid ||  prefer1_r);
      push0_s     = i_req0_valid && ready0_s;
      push1_s     = i_req1_valid && ready1_s;
      push_s      = push0_s || push1_s;
      if (push0_s) begin
         push_data_s = i_req0_data;
      end else begin
         push_data_s = i_req1_data;
      end
   end

   // Sequencer next-state, counter updates and pop request.
   always_comb begin
      state_s       = state_r;
      pop_s         = 1'b0;
      timeout_set_s = 1'b0;
      tout_cnt_s    = tout_cnt_r;
      gap_cnt_s     = gap_cnt_r;
      case (state_r)
         IDLE: begin
            if (i_enable && !empty_s) begin
               pop_s   = 1'b1;
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            tout_cnt_s = TW'(0);
            state_s    = WAIT;
         end
         WAIT: begin
            if (i_tx_done) begin
               if (GAP_CYCLES == 0) begin
                  state_s = IDLE;
               end else begin
                  gap_cnt_s = GW'(GAP_CYCLES);
                  state_s   = GAP;
               end
            end else if ((tout_cnt_r + TW'(1)) == TW'(TIMEOUT_CYCLES - 1)) begin
               // Abort lands on the edge where the counter reaches its limit.
               tout_cnt_s    = tout_cnt_r + TW'(1);
               timeout_set_s = 1'b1;
               state_s       = IDLE;
            end else begin
               tout_cnt_s = tout_cnt_r + TW'(1);
            end
         end
         GAP: begin
            if (gap_cnt_r <= GW'(1)) begin
               state_s = IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - GW'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Next occupancy; push is already blocked when full and pop when empty.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   level_s = level_r + LW'(1);
         2'b01:   level_s = level_r - LW'(1);
         default: level_s = level_r;
      endcase
   end

   // FIFO storage array (data only, no reset needed).
   always_ff @(posedge pClk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers, occupancy and round-robin pointer.
   always_ff @(posedge pClk) begin
      if (pReset) begin
         wr_ptr_r  <= AW'(0);
         rd_ptr_r  <= AW'(0);
         level_r   <= LW'(0);
         prefer1_r <= 1'b0;
      end else begin
         level_r <= level_s;
         if (push_s) begin
            wr_ptr_r  <= wr_ptr_r + AW'(1);
            prefer1_r <= push0_s;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
      end
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge pClk) begin
      if (pReset) begin
         state_r    <= IDLE;
         tout_cnt_r <= TW'(0);
         gap_cnt_r  <= GW'(0);
         tx_data_r  <= 8'h00;
         tx_start_r <= 1'b0;
         timeout_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         tout_cnt_r <= tout_cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         tx_start_r <= (state_s == START);
         busy_r     <= (state_s != IDLE) || (level_s != LW'(0));
         if (pop_s) begin
            tx_data_r <= fifo_mem_r[rd_ptr_r];
         end
         // Setting the flag wins over a simultaneous clear.
         if (timeout_set_s) begin
            timeout_r <= 1'b1;
         end else if (i_clr_timeout) begin
            timeout_r <= 1'b0;
         end
      end
   end

   assign o_req0_ready = ready0_s;
   assign o_req1_ready = ready1_s;
   assign o_tx_start   = tx_start_r;
   assign o_tx_data    = tx_data_r;
   assign o_level      = level_r;
   assign o_busy       = busy_r;
   assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed self-checking bench for uart_tx_sched (DEPTH=8, GAP_CYCLES=16,
//   TIMEOUT_CYCLES=50). A small responder returns i_tx_done three cycles
//   after each start while auto_done is set; a monitor logs every started
//   byte so frame order can be compared against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

   logic       pClk = 1'b0;
   logic       pReset;
   logic       i_enable;
   logic       i_req0_valid;
   logic [7:0] i_req0_data;
   logic       o_req0_ready;
   logic       i_req1_valid;
   logic [7:0] i_req1_data;
   logic       o_req1_ready;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       i_tx_done;
   logic       i_clr_timeout;
   logic [3:0] o_level;
   logic       o_busy;
   logic       o_timeout;

   int         checks = 0;
   int         errors = 0;
   logic       auto_done = 1'b0;
   logic [7:0] tx_log [$];

   uart_tx_sched #(
      .DEPTH          (8),
      .GAP_CYCLES     (16),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .pClk          (pClk),
      .pReset        (pReset),
      .i_enable      (i_enable),
      .i_req0_valid  (i_req0_valid),
      .i_req0_data   (i_req0_data),
      .o_req0_ready  (o_req0_ready),
      .i_req1_valid  (i_req1_valid),
      .i_req1_data   (i_req1_data),
      .o_req1_ready  (o_req1_ready),
      .o_tx_start    (o_tx_start),
      .o_tx_data     (o_tx_data),
      .i_tx_done     (i_tx_done),
      .i_clr_timeout (i_clr_timeout),
      .o_level       (o_level),
      .o_busy        (o_busy),
      .o_timeout     (o_timeout)
   );

   always #5 pClk = ~pClk;

   // Log every started byte, sampled away from the active edge.
   always @(negedge pClk) begin
      if (o_tx_start === 1'b1) tx_log.push_back(o_tx_data);
   end

   task automatic step();
      @(posedge pClk);
      #1;
   endtask

   // UART_TX stand-in: done pulse three cycles after each start.
   initial begin
      forever begin
         @(posedge pClk);
         #1;
         if (o_tx_start === 1'b1 && auto_done) begin
            repeat (3) begin
               @(posedge pClk);
               #1;
            end
            i_tx_done = 1'b1;
            @(posedge pClk);
            #1;
            i_tx_done = 1'b0;
         end
      end
   end

   task automatic do_reset();
      pReset = 1'b1; i_enable = 1'b0; i_clr_timeout = 1'b0; i_tx_done = 1'b0;
      i_req0_valid = 1'b0; i_req0_data = 8'h00;
      i_req1_valid = 1'b0; i_req1_data = 8'h00;
      step();
      step();
      pReset = 1'b0;
      tx_log.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", o_level); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got start=%b data=%h expected 0/00", o_tx_start, o_tx_data); end
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      #1;
      checks++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rr_favour0: got r0=%b r1=%b expected 1/0", o_req0_ready, o_req1_ready); end
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
   endtask

   task automatic test_single_byte();
      do_reset();
      auto_done = 1'b0;
      i_enable = 1'b1;
      i_req0_valid = 1'b1; i_req0_data = 8'hA5;
      step();
      i_req0_valid = 1'b0;
      checks++; if (o_level !== 4'd1 || o_tx_start !== 1'b0) begin errors++; $display("FAIL single_push: got level=%0d start=%b expected 1/0", o_level, o_tx_start); end
      step();
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA5 || o_level !== 4'd0) begin errors++; $display("FAIL single_start: got start=%b data=%h level=%0d expected 1/a5/0", o_tx_start, o_tx_data, o_level); end
      step();
      checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", o_tx_start); end
      step();
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      repeat (15) step();
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b expected 1", o_busy); end
      step();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", o_busy); end
      checks++; if (tx_log.size() !== 1) begin errors++; $display("FAIL single_count: got %0d starts expected 1", tx_log.size()); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_order [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
      int i0 = 0;
      int i1 = 0;
      do_reset();
      auto_done = 1'b1;
      i_enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i_req0_valid = 1'b1; i_req0_data = 8'h10 + 8'(i0);
         i_req1_valid = 1'b1; i_req1_data = 8'h20 + 8'(i1);
         #1;
         checks++; if (o_req0_ready !== ((k % 2) == 0) || o_req1_ready !== ((k % 2) == 1)) begin errors++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected r0=%b", k, o_req0_ready, o_req1_ready, ((k % 2) == 0)); end
         if (o_req0_ready) i0++;
         if (o_req1_ready) i1++;
         step();
      end
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      for (int c = 0; c < 600 && tx_log.size() < 8; c++) step();
      checks++; if (tx_log.size() !== 8) begin errors++; $display("FAIL rr_frames: got %0d frames expected 8", tx_log.size()); end
      for (int k = 0; k < 8 && k < tx_log.size(); k++) begin
         checks++; if (tx_log[k] !== exp_order[k]) begin errors++; $display("FAIL rr_order[%0d]: got %h expected %h", k, tx_log[k], exp_order[k]); end
      end
      auto_done = 1'b0;
   endtask

   task automatic test_full_fifo();
      do_reset();
      auto_done = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i_req0_valid = 1'b1; i_req0_data = 8'h30 + 8'(k);
         step();
      end
      i_req0_data = 8'h38;
      #1;
      checks++; if (o_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", o_level); end
      checks++; if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got r0=%b r1=%b expected 0/0", o_req0_ready, o_req1_ready); end
      step();
      checks++; if (o_level !== 4'd8) begin errors++; $display("FAIL full_hold: got %0d expected 8", o_level); end
      i_enable = 1'b1;
      step();
      checks++; if (o_level !== 4'd7 || o_req0_ready !== 1'b1) begin errors++; $display("FAIL full_pop: got level=%0d r0=%b expected 7/1", o_level, o_req0_ready); end
      step();
      i_req0_valid = 1'b0;
      checks++; if (o_level !== 4'd8) begin errors++; $display("FAIL full_refill: got %0d expected 8", o_level); end
      for (int c = 0; c < 1000 && tx_log.size() < 9; c++) step();
      checks++; if (tx_log.size() !== 9) begin errors++; $display("FAIL full_frames: got %0d expected 9", tx_log.size()); end
      if (tx_log.size() == 9) begin
         checks++; if (tx_log[0] !== 8'h30 || tx_log[8] !== 8'h38) begin errors++; $display("FAIL full_order: got %h..%h expected 30..38", tx_log[0], tx_log[8]); end
      end
      auto_done = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      auto_done = 1'b0;
      i_enable = 1'b1;
      i_req0_valid = 1'b1; i_req0_data = 8'h41;
      step();
      i_req0_data = 8'h42;
      step();
      i_req0_valid = 1'b0;
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h41) begin errors++; $display("FAIL to_first_start: got start=%b data=%h expected 1/41", o_tx_start, o_tx_data); end
      repeat (49) step();
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", o_timeout); end
      step();
      checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", o_timeout); end
      step();
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h42) begin errors++; $display("FAIL to_next_start: got start=%b data=%h expected 1/42", o_tx_start, o_tx_data); end
      i_clr_timeout = 1'b1;
      step();
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", o_timeout); end
      repeat (48) step();
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_clear_hold: got %b expected 0", o_timeout); end
      step();
      checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_set_priority: got %b expected 1", o_timeout); end
      i_clr_timeout = 1'b0;
   endtask

   task automatic test_disable_mid_frame();
      do_reset();
      auto_done = 1'b0;
      i_enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_req0_valid = 1'b1; i_req0_data = 8'h51 + 8'(k);
         step();
      end
      i_req0_valid = 1'b0;
      i_enable = 1'b0;
      checks++; if (o_level !== 4'd3) begin errors++; $display("FAIL dis_queued: got %0d expected 3", o_level); end
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      repeat (30) step();
      checks++; if (tx_log.size() !== 1 || o_level !== 4'd3) begin errors++; $display("FAIL dis_hold: got starts=%0d level=%0d expected 1/3", tx_log.size(), o_level); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dis_busy: got %b expected 1", o_busy); end
      i_enable = 1'b1;
      for (int c = 0; c < 10 && tx_log.size() < 2; c++) step();
      checks++; if (tx_log.size() !== 2) begin errors++; $display("FAIL dis_resume: got %0d starts expected 2", tx_log.size()); end
      else begin
         checks++; if (tx_log[1] !== 8'h52) begin errors++; $display("FAIL dis_resume_data: got %h expected 52", tx_log[1]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      int n0;
      do_reset();
      auto_done = 1'b0;
      i_enable = 1'b1;
      i_req0_valid = 1'b1; i_req0_data = 8'h61;
      step();
      i_req0_data = 8'h62;
      step();
      i_req0_valid = 1'b0;
      step();
      step();
      n0 = tx_log.size();
      pReset = 1'b1;
      step();
      pReset = 1'b0;
      checks++; if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00 || o_level !== 4'd0 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL rst_wait_outputs: got start=%b data=%h level=%0d busy=%b to=%b expected all 0", o_tx_start, o_tx_data, o_level, o_busy, o_timeout); end
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      repeat (30) step();
      checks++; if (tx_log.size() !== n0 || o_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_quiet: got starts=%0d busy=%b expected %0d/0", tx_log.size(), o_busy, n0); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_full_fifo();
      test_timeout();
      test_disable_mid_frame();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit-side controller for the UART. It round-robin arbitrates two byte requesters (APB register write path and RX loopback/echo path) into a TX FIFO. It then sequences the UART_TX engine one frame at a time: start pulse, wait for done, enforce an inter-frame gap. It replaces the direct button-edge/register drive of the TX engine and sits between UART_Register, UART_RX and UART_TX.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
GAP_CYCLES, 16, idle pClk cycles after each frame's done before the next start; 0 means no gap
TIMEOUT_CYCLES, 200000, pClk cycles to wait for i_tx_done before aborting the frame

Ports:
pClk  in  1  system clock, single clock domain
pReset  in  1  synchronous, active-high reset
i_enable  in  1  when 0, no new frame is started; the FIFO still accepts bytes
i_req0_valid  in  1  requester 0 (APB write path) has a byte
i_req0_data  in  8  requester 0 byte
o_req0_ready  out  1  requester 0 granted; transfer occurs when valid & ready
i_req1_valid  in  1  requester 1 (RX echo path) has a byte
i_req1_data  in  8  requester 1 byte
o_req1_ready  out  1  requester 1 granted
o_tx_start  out  1  one-cycle start pulse to UART_TX
o_tx_data  out  8  byte for UART_TX; held stable from start until done or timeout
i_tx_done  in  1  one-cycle pulse from UART_TX at the end of the stop bit
i_clr_timeout  in  1  clears o_timeout
o_level  out  clog2(DEPTH)+1  FIFO occupancy
o_busy  out  1  state is not IDLE, or o_level is nonzero
o_timeout  out  1  sticky flag: a frame was aborted because done never arrived

Behaviour:
- Reset (synchronous, pReset=1 at a pClk edge):
  - state=IDLE; FIFO pointers=0; o_level=0; o_tx_start=0; o_tx_data=0; o_timeout=0; gap and timeout counters=0.
  - Round-robin pointer favours req0.
  - Reset mid-frame abandons the frame immediately; no start pulse is issued afterwards.
- Arbitration (ready signals are combinational):
  - If FIFO full: both readies are 0.
  - If not full and only one requester is valid: that requester gets ready.
  - If not full and both are valid: the requester not granted last gets ready.
  - The pointer updates only on an actual transfer.
  - At most one push per cycle.
  - A requester's ready never depends on its own valid being high only through the other requester (no combinational loop).
- FIFO:
  - Push when valid & ready. Pop only by the sequencer.
  - Full and empty are evaluated at cycle start. A simultaneous push and pop when non-empty and non-full leaves o_level unchanged.
  - No push while full, even if a pop occurs in the same cycle.
  - No pop while empty, so there is no bypass.
  - Pointers wrap modulo DEPTH; o_level goes 0..DEPTH.
- Sequencer FSM:
  - IDLE: if i_enable and o_level>0, pop the head into o_tx_data and go to START.
  - START: o_tx_start=1 for exactly this cycle; go to WAIT; clear the timeout counter.
  - WAIT:
    - On i_tx_done: go to GAP, loading GAP_CYCLES; if GAP_CYCLES=0, go straight to IDLE.
    - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without done, set o_timeout and go to IDLE.
  - GAP: decrement; go to IDLE when the counter reaches 1 (exactly GAP_CYCLES cycles spent in GAP).
  - i_tx_done outside WAIT is ignored.
- Latency: with an empty FIFO, IDLE state and enabled, a push on edge N gives o_level=1 after N, the pop at N+1, and o_tx_start high in the cycle after edge N+1.
- Start spacing: minimum spacing between starts is done-cycle + GAP_CYCLES + 2 cycles.
- i_enable=0 mid-frame: the current frame completes, including the gap; no further pop.
- o_timeout: set has priority over i_clr_timeout in the same cycle.

Test Plan:
- Single byte: reset, then push 0xA5 on req0 → one o_tx_start pulse 2 cycles later with o_tx_data=0xA5. Return done → GAP for 16 cycles, then IDLE, o_busy=0.
- Round-robin: both requesters valid continuously with 0x10..0x13 and 0x20..0x23 → FIFO order 0x10,0x20,0x11,0x21,…; frames are transmitted in that order.
- Full FIFO: i_enable=0, push 9 bytes → o_level=8, both readies 0 on the 9th attempt. Set i_enable=1 → the 9th byte is accepted one cycle after the first pop.
- Timeout: TIMEOUT_CYCLES=50, never send done → o_timeout=1 exactly 50 cycles after the start cycle, FSM back in IDLE and the next byte is started. Pulse i_clr_timeout → o_timeout=0.
- Disable mid-frame: deassert i_enable during WAIT with 3 bytes queued → the current frame finishes, no new start, o_level=3. Re-enable → transmission resumes.
- Reset mid-WAIT: assert pReset → all outputs 0, o_level=0, a late i_tx_done is ignored, no start pulse appears.
